// File: rtl/spu_sm_pkg.sv
// Shared definitions for the softmax sequencer and the softmax datapath block.
package spu_sm_pkg;

  // Phase code driven to the softmax block on sm_state.
  typedef enum logic [2:0] {
    StIdle = 3'b000,
    StEuA  = 3'b001,
    StReci = 3'b011,
    StEuB  = 3'b100,
    StMax  = 3'b101
  } sm_state_e;

  // Default datapath latencies.
  localparam int unsigned RdLatDef   = 1;
  localparam int unsigned ExpLatDef  = 2;
  localparam int unsigned TreeLatDef = 3;

  // Phases that sweep the row buffer.
  function automatic logic is_read_phase(sm_state_e s);
    return (s == StMax) || (s == StEuA) || (s == StEuB);
  endfunction

endpackage

// File: rtl/spu_sm_ctrl_dly.sv
// Fixed-depth delay line for a strobe and its payload (e.g. valid + address).
module spu_sm_ctrl_dly #(
  parameter int unsigned Depth = 1,  // must be >= 1
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o
);

  logic [Width-1:0] pipe_q [Depth];

  // Shift register, cleared synchronously.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[Depth-1];

endmodule

// File: rtl/spu_sm_ctrl.sv
// Softmax sequencer: per row runs MAX, EU_STAGE_A, RECI handshake, EU_STAGE_B.
module spu_sm_ctrl
  import spu_sm_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned LEN_W    = 10,
  parameter int unsigned ROW_W    = 12,
  parameter int unsigned RD_LAT   = RdLatDef,
  parameter int unsigned EXP_LAT  = ExpLatDef,
  parameter int unsigned TREE_LAT = TreeLatDef
) (
  input  logic              core_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_wr_base,
  input  logic [LEN_W-1:0]  cfg_row_words,
  input  logic [ROW_W-1:0]  cfg_num_rows,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        sm_state,
  output logic              comp_en,
  output logic              comp_rst,
  output logic              adder_tree_en,
  output logic              reci_exp_sum_en,
  input  logic              reci_exp_sum_finish
);

  localparam int unsigned ExecLat = RD_LAT + EXP_LAT;

  // Last drain count per phase. MAX and EU_STAGE_A carry one extra phase-transition
  // cycle on top of their pipeline drain; EU_STAGE_B ends on its final write.
  localparam logic [LEN_W-1:0] DrainMaxLast = LEN_W'(RD_LAT);
  localparam logic [LEN_W-1:0] DrainALast   = LEN_W'(RD_LAT + EXP_LAT + TREE_LAT);
  localparam logic [LEN_W-1:0] DrainBLast   = LEN_W'(ExecLat - 1);

  sm_state_e         state_q, state_d;
  logic              drain_q, drain_d;      // 0: ISSUE, 1: DRAIN
  logic [LEN_W-1:0]  cnt_q, cnt_d;          // word index, drain count, or RECI-entered flag
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_off_q, row_off_d;  // row * row_words, modulo 2^ADDR_W
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic              zero_done_q, zero_done_d;

  logic              row_last;
  logic [LEN_W-1:0]  drain_last;
  logic [ADDR_W-1:0] word_off;
  logic [ADDR_W-1:0] wr_addr_src;
  logic              max_rd, eua_rd, eub_rd;
  logic [ADDR_W:0]   wr_dly_in, wr_dly_out;

  assign row_last = (row_q + ROW_W'(1)) >= rows_q;
  assign word_off = ADDR_W'(cnt_q);

  // Drain length of the current read phase.
  always_comb begin
    drain_last = '0;
    unique case (state_q)
      StMax:   drain_last = DrainMaxLast;
      StEuA:   drain_last = DrainALast;
      StEuB:   drain_last = DrainBLast;
      default: drain_last = '0;
    endcase
  end

  // State and configuration registers.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      drain_q     <= 1'b0;
      cnt_q       <= '0;
      row_q       <= '0;
      row_off_q   <= '0;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      words_q     <= '0;
      rows_q      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      row_off_q   <= row_off_d;
      rd_base_q   <= rd_base_d;
      wr_base_q   <= wr_base_d;
      words_q     <= words_d;
      rows_q      <= rows_d;
      zero_done_q <= zero_done_d;
    end
  end

  // Next-state logic: ISSUE/DRAIN sequencing within a phase, phase and row transitions.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    row_off_d   = row_off_q;
    rd_base_d   = rd_base_q;
    wr_base_d   = wr_base_q;
    words_d     = words_q;
    rows_d      = rows_q;
    zero_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rd_base_d = cfg_rd_base;
          wr_base_d = cfg_wr_base;
          words_d   = cfg_row_words;
          rows_d    = cfg_num_rows;
          if (cfg_row_words == '0 || cfg_num_rows == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d   = StMax;
            drain_d   = 1'b0;
            cnt_d     = '0;
            row_d     = '0;
            row_off_d = '0;
          end
        end
      end
      StMax, StEuA, StEuB: begin
        if (!drain_q) begin
          if (cnt_q == words_q - LEN_W'(1)) begin
            drain_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end else if (cnt_q != drain_last) begin
          cnt_d = cnt_q + LEN_W'(1);
        end else begin
          drain_d = 1'b0;
          cnt_d   = '0;
          if (state_q == StMax) begin
            state_d = StEuA;
          end else if (state_q == StEuA) begin
            state_d = StReci;
          end else if (row_last) begin
            state_d = StIdle;
          end else begin
            state_d   = StMax;
            row_d     = row_q + ROW_W'(1);
            row_off_d = row_off_q + ADDR_W'(words_q);
          end
        end
      end
      StReci: begin
        // cnt_q == 0 only in the first RECI cycle, which fires the divider pulse.
        cnt_d = LEN_W'(1);
        if (reci_exp_sum_finish) begin
          state_d = StEuB;
          drain_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes and addresses decoded from the current state.
  always_comb begin
    busy            = state_q != StIdle;
    rd_en           = is_read_phase(state_q) && !drain_q;
    rd_addr         = '0;
    wr_addr_src     = wr_base_q + row_off_q + word_off;
    comp_rst        = (state_q == StMax) && rd_en && (cnt_q == '0);
    reci_exp_sum_en = (state_q == StReci) && (cnt_q == '0);
    done            = zero_done_q ||
                      ((state_q == StEuB) && drain_q && (cnt_q == DrainBLast) && row_last);
    max_rd          = rd_en && (state_q == StMax);
    eua_rd          = rd_en && (state_q == StEuA);
    eub_rd          = rd_en && (state_q == StEuB);
    wr_dly_in       = '0;
    if (rd_en) rd_addr = rd_base_q + row_off_q + word_off;
    if (eub_rd) wr_dly_in = {1'b1, wr_addr_src};
  end

  assign sm_state = state_q;

  spu_sm_ctrl_dly #(
    .Depth(RD_LAT),
    .Width(1)
  ) u_dly_comp (
    .clk_i (core_clk),
    .rst_i (rst),
    .din_i (max_rd),
    .dout_o(comp_en)
  );

  spu_sm_ctrl_dly #(
    .Depth(ExecLat),
    .Width(1)
  ) u_dly_tree (
    .clk_i (core_clk),
    .rst_i (rst),
    .din_i (eua_rd),
    .dout_o(adder_tree_en)
  );

  // Write strobe and address travel together so wr_addr lines up with the requantizer output.
  spu_sm_ctrl_dly #(
    .Depth(ExecLat),
    .Width(ADDR_W + 1)
  ) u_dly_wr (
    .clk_i (core_clk),
    .rst_i (rst),
    .din_i (wr_dly_in),
    .dout_o(wr_dly_out)
  );

  assign wr_en   = wr_dly_out[ADDR_W];
  assign wr_addr = wr_dly_out[ADDR_W-1:0];

endmodule

// File: tb/tb_spu_sm_ctrl.sv
// Self-checking bench for spu_sm_ctrl: vector table, hand corner cases, random commands.
module tb_spu_sm_ctrl;

  localparam int AW = 12;
  localparam int LW = 10;
  localparam int RW = 12;
  localparam int RD = 1;
  localparam int EX = 2;
  localparam int TR = 3;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_A    = 3'b001;
  localparam logic [2:0] S_RECI = 3'b011;
  localparam logic [2:0] S_B    = 3'b100;
  localparam logic [2:0] S_MAX  = 3'b101;

  logic          core_clk, rst, start;
  logic [AW-1:0] cfg_rd_base, cfg_wr_base;
  logic [LW-1:0] cfg_row_words;
  logic [RW-1:0] cfg_num_rows;
  logic          busy, done, rd_en, wr_en, comp_en, comp_rst, adder_tree_en;
  logic          reci_exp_sum_en, reci_exp_sum_finish;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [2:0]    sm_state;

  spu_sm_ctrl dut (
    .core_clk           (core_clk),
    .rst                (rst),
    .start              (start),
    .cfg_rd_base        (cfg_rd_base),
    .cfg_wr_base        (cfg_wr_base),
    .cfg_row_words      (cfg_row_words),
    .cfg_num_rows       (cfg_num_rows),
    .busy               (busy),
    .done               (done),
    .rd_en              (rd_en),
    .rd_addr            (rd_addr),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .sm_state           (sm_state),
    .comp_en            (comp_en),
    .comp_rst           (comp_rst),
    .adder_tree_en      (adder_tree_en),
    .reci_exp_sum_en    (reci_exp_sum_en),
    .reci_exp_sum_finish(reci_exp_sum_finish)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  typedef struct {
    logic [11:0] rd_base;
    logic [11:0] wr_base;
    int          words;
    int          rows;
    int          dly;         // divider ack delay after each pulse
    int          poke;        // relative cycle of a start-while-busy, 0 = none
    int          exp_done;    // hand-computed done cycle after acceptance, -1 = skip
    int          exp_nwr;
    logic [11:0] exp_last_wr;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Capture of one command.
  bit          rec = 0;
  int          rd_max_c[$], rd_a_c[$], rd_b_c[$], comp_c[$], add_c[$], wr_c[$];
  int          fin_c[$], reci_c[$];
  logic [14:0] rd_ev[$];
  logic [11:0] wr_ev[$];
  int          n_comp_rst, n_done, n_busy, n_reci_cyc, viol;

  // Divider responder.
  bit auto_fin = 1;
  bit fin_armed = 0;
  int fin_cnt = 0;
  int fin_pend[$];
  int row_dly[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outvec();
    return 64'({busy, done, rd_en, rd_addr, wr_en, wr_addr, sm_state, comp_en, comp_rst,
                adder_tree_en, reci_exp_sum_en});
  endfunction

  function automatic int align_err(input int a[$], input int b[$], input int lat);
    int m = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (b[i] != a[i] + lat) m++;
    return m;
  endfunction

  // Advance to the next falling edge, answer the divider, record what the DUT shows.
  task automatic tick();
    @(negedge core_clk);
    cyc++;
    if (auto_fin) begin
      reci_exp_sum_finish = 1'b0;
      if (reci_exp_sum_en) begin
        fin_cnt   = (fin_pend.size() > 0) ? fin_pend.pop_front() : 0;
        fin_armed = 1;
      end
      if (fin_armed) begin
        if (fin_cnt == 0) begin
          reci_exp_sum_finish = 1'b1;
          fin_armed = 0;
        end else begin
          fin_cnt--;
        end
      end
    end
    if (rec) begin
      if (rd_en) begin
        rd_ev.push_back({sm_state, rd_addr});
        case (sm_state)
          S_MAX:   rd_max_c.push_back(cyc);
          S_A:     rd_a_c.push_back(cyc);
          S_B:     rd_b_c.push_back(cyc);
          default: viol++;
        endcase
      end
      if (comp_en) begin comp_c.push_back(cyc); if (sm_state != S_MAX) viol++; end
      if (adder_tree_en) begin add_c.push_back(cyc); if (sm_state != S_A) viol++; end
      if (wr_en) begin
        wr_c.push_back(cyc);
        wr_ev.push_back(wr_addr);
        if (sm_state != S_B) viol++;
      end
      if (reci_exp_sum_en) begin reci_c.push_back(cyc); if (sm_state != S_RECI) viol++; end
      if (comp_rst) begin n_comp_rst++; if (!(rd_en && sm_state == S_MAX)) viol++; end
      if (sm_state == S_RECI) begin
        n_reci_cyc++;
        if (rd_en || comp_en || adder_tree_en || wr_en) viol++;
      end
      if (reci_exp_sum_finish && sm_state == S_RECI) fin_c.push_back(cyc);
      if (done) n_done++;
      if (busy) n_busy++;
    end
  endtask

  // Issue one command (start in the current cycle) and compare against the reference model.
  task automatic run_cmd(input vec_t v, input string tag);
    logic [14:0] exp_rd[$];
    logic [11:0] exp_wr[$];
    int exp_done = 0, exp_reci = 0, t0, done_rel = -1, m;
    bit zero = (v.words == 0) || (v.rows == 0);

    // Reference model: addresses and timing straight from the row/phase rules.
    if (zero) begin
      exp_done = 1;
    end else begin
      for (int r = 0; r < v.rows; r++) begin
        for (int k = 0; k < v.words; k++)
          exp_rd.push_back({S_MAX, 12'((int'(v.rd_base) + r * v.words + k) % 4096)});
        for (int k = 0; k < v.words; k++)
          exp_rd.push_back({S_A, 12'((int'(v.rd_base) + r * v.words + k) % 4096)});
        for (int k = 0; k < v.words; k++) begin
          exp_rd.push_back({S_B, 12'((int'(v.rd_base) + r * v.words + k) % 4096)});
          exp_wr.push_back(12'((int'(v.wr_base) + r * v.words + k) % 4096));
        end
        exp_done += 3 * v.words + 3 * RD + 2 * EX + TR + row_dly[r] + 3;
        exp_reci += 1 + row_dly[r];
      end
    end

    rd_max_c.delete(); rd_a_c.delete(); rd_b_c.delete(); comp_c.delete(); add_c.delete();
    wr_c.delete(); fin_c.delete(); reci_c.delete(); rd_ev.delete(); wr_ev.delete();
    n_comp_rst = 0; n_done = 0; n_busy = 0; n_reci_cyc = 0; viol = 0;
    fin_pend.delete();
    fin_armed = 0;
    if (!zero) foreach (row_dly[i]) fin_pend.push_back(row_dly[i]);

    cfg_rd_base   = v.rd_base;
    cfg_wr_base   = v.wr_base;
    cfg_row_words = LW'(v.words);
    cfg_num_rows  = RW'(v.rows);
    start = 1'b1;
    t0  = cyc;
    rec = 1;
    for (int i = 0; i < exp_done + 20 && done_rel < 0; i++) begin
      tick();
      start = 1'b0;
      cfg_rd_base   = AW'($urandom);
      cfg_wr_base   = AW'($urandom);
      cfg_row_words = LW'($urandom_range(0, 7));
      cfg_num_rows  = RW'($urandom_range(0, 3));
      if (v.poke > 0 && cyc - t0 == v.poke) start = 1'b1;
      if (done) done_rel = cyc - t0;
    end
    start = 1'b0;
    tick();
    check({tag, "_busy_after_done"}, 64'(busy), 64'(0));
    rec = 0;

    check({tag, "_done_cycle"}, 64'(done_rel), 64'(exp_done));
    if (v.exp_done >= 0) check({tag, "_done_hand"}, 64'(done_rel), 64'(v.exp_done));
    check({tag, "_done_pulses"}, 64'(n_done), 64'(1));
    check({tag, "_busy_cycles"}, 64'(n_busy), 64'(zero ? 0 : exp_done));
    check({tag, "_rd_count"}, 64'(rd_ev.size()), 64'(exp_rd.size()));
    m = 0;
    foreach (exp_rd[i]) if (i >= rd_ev.size() || rd_ev[i] !== exp_rd[i]) m++;
    check({tag, "_rd_seq_errs"}, 64'(m), 64'(0));
    check({tag, "_wr_count"}, 64'(wr_ev.size()), 64'(exp_wr.size()));
    m = 0;
    foreach (exp_wr[i]) if (i >= wr_ev.size() || wr_ev[i] !== exp_wr[i]) m++;
    check({tag, "_wr_seq_errs"}, 64'(m), 64'(0));
    if (v.exp_done >= 0) begin
      check({tag, "_wr_count_hand"}, 64'(wr_ev.size()), 64'(v.exp_nwr));
      if (v.exp_nwr > 0 && wr_ev.size() > 0)
        check({tag, "_wr_last_hand"}, 64'(wr_ev[wr_ev.size()-1]), 64'(v.exp_last_wr));
    end
    check({tag, "_comp_rst_pulses"}, 64'(n_comp_rst), 64'(zero ? 0 : v.rows));
    check({tag, "_reci_pulses"}, 64'(reci_c.size()), 64'(zero ? 0 : v.rows));
    check({tag, "_reci_cycles"}, 64'(n_reci_cyc), 64'(exp_reci));
    check({tag, "_comp_align_errs"}, 64'(align_err(rd_max_c, comp_c, RD)), 64'(0));
    check({tag, "_tree_align_errs"}, 64'(align_err(rd_a_c, add_c, RD + EX)), 64'(0));
    check({tag, "_wr_align_errs"}, 64'(align_err(rd_b_c, wr_c, RD + EX)), 64'(0));
    m = 0;
    if (!zero) begin
      for (int r = 0; r < v.rows; r++) begin
        if (rd_b_c.size() > r * v.words && fin_c.size() > r) begin
          if (rd_b_c[r * v.words] != fin_c[r] + 1) m++;
        end else begin
          m++;
        end
      end
    end
    check({tag, "_euB_after_finish_errs"}, 64'(m), 64'(0));
    check({tag, "_phase_violations"}, 64'(viol), 64'(0));
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    int nz;

    vecs[0] = '{12'h000, 12'h300, 4, 1, 5,   0, 30,  4, 12'h303};  // single row
    vecs[1] = '{12'h100, 12'h200, 2, 3, 0,   0, 57,  6, 12'h205};  // multi-row
    vecs[2] = '{12'h050, 12'h060, 0, 5, 0,   0, 1,   0, 12'h000};  // zero words
    vecs[3] = '{12'h050, 12'h060, 3, 0, 0,   0, 1,   0, 12'h000};  // zero rows
    vecs[4] = '{12'hFFE, 12'h010, 4, 1, 2,   3, 27,  4, 12'h013};  // wrap + start while busy
    vecs[5] = '{12'h040, 12'h080, 2, 1, 100, 0, 119, 2, 12'h081};  // divider stall
    vecs[6] = '{12'h7F0, 12'hFFD, 3, 2, 1,   0, 46,  6, 12'h002};  // write wrap, back-to-back

    rst = 1'b1;
    start = 1'b0;
    cfg_rd_base = '0;
    cfg_wr_base = '0;
    cfg_row_words = '0;
    cfg_num_rows = '0;
    reci_exp_sum_finish = 1'b0;
    tick();
    tick();
    check("reset_outputs", outvec(), 64'(0));
    check("reset_state", 64'(sm_state), 64'(S_IDLE));
    rst = 1'b0;
    tick();

    // Table-driven commands, back to back.
    for (int i = 0; i < 7; i++) begin
      row_dly.delete();
      for (int r = 0; r < vecs[i].rows; r++) row_dly.push_back(vecs[i].dly);
      run_cmd(vecs[i], $sformatf("vec%0d", i));
      if (i == 4) begin
        check("wrap_rd0", 64'(rd_ev[0][11:0]), 64'(12'hFFE));
        check("wrap_rd2", 64'(rd_ev[2][11:0]), 64'(12'h000));
        check("wrap_rd3", 64'(rd_ev[3][11:0]), 64'(12'h001));
      end
    end

    // Reset during EU_STAGE_A, then a stray divider ack while idle.
    row_dly.delete();
    row_dly.push_back(4);
    row_dly.push_back(4);
    fin_pend = row_dly;
    cfg_rd_base = 12'h020;
    cfg_wr_base = 12'h0A0;
    cfg_row_words = 10'd3;
    cfg_num_rows = 12'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && sm_state != S_A; i++) tick();
    check("reach_eu_a", 64'(sm_state), 64'(S_A));
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_reset_outputs", outvec(), 64'(0));
    rst = 1'b0;
    auto_fin = 0;
    fin_armed = 0;
    fin_pend.delete();
    reci_exp_sum_finish = 1'b1;
    tick();
    reci_exp_sum_finish = 1'b0;
    nz = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (outvec() != 64'(0)) nz++;
    end
    check("late_finish_ignored", 64'(nz), 64'(0));
    auto_fin = 1;
    row_dly.delete();
    row_dly.push_back(1);
    v = '{12'h020, 12'h0A0, 3, 1, 1, 0, 23, 3, 12'h0A2};
    run_cmd(v, "post_reset");

    // Random commands against the reference model.
    for (int i = 0; i < 8; i++) begin
      v.rd_base = 12'($urandom);
      v.wr_base = 12'($urandom);
      v.words   = $urandom_range(1, 6);
      v.rows    = $urandom_range(1, 3);
      v.dly     = 0;
      v.poke    = $urandom_range(0, 4);
      v.exp_done = -1;
      v.exp_nwr  = 0;
      v.exp_last_wr = 12'h000;
      row_dly.delete();
      for (int r = 0; r < v.rows; r++) row_dly.push_back($urandom_range(0, 6));
      run_cmd(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
